// File: rtl/loader_pkg.sv
// Shared definitions for the UART program loader: loader states, the frame
// sync byte and the byte counts of each frame field.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam int unsigned LEN_BYTES  = 4;  // little-endian word count
  localparam int unsigned WORD_BYTES = 4;  // little-endian data word
  localparam int unsigned CHK_BYTES  = 1;  // modulo-256 checksum

  // Index of the final byte within a 4-byte field, in byte-counter width.
  localparam logic [1:0] LAST_BYTE_IDX = 2'(WORD_BYTES - 1);

endpackage

// File: rtl/prog_loader.sv
// UART program loader: receives a framed program image byte by byte, writes
// each 32-bit word to memory over a native valid/ready port, verifies the
// checksum and releases the CPU from reset only after a clean load.
module prog_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        cpu_reset_n,
  output logic        done,
  output logic        error
);

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q,   cnt_d;    // byte position inside current 4-byte field
  logic [23:0] shift_q, shift_d;  // first three bytes of the field, LE
  logic [31:0] word_q,  word_d;   // word being written
  logic [31:0] len_q,   len_d;    // N
  logic [31:0] idx_q,   idx_d;    // i, words written so far
  logic [7:0]  cksum_q, cksum_d;

  logic        rx_fire;
  logic [31:0] assembled;
  logic        last_byte;
  logic [31:0] idx_inc;

  // Handshake and byte assembly helpers.
  always_comb begin
    rx_ready  = !reset && (state_q != ST_WRITE);
    rx_fire   = rx_valid && rx_ready;
    assembled = {rx_data, shift_q};
    last_byte = (cnt_q == LAST_BYTE_IDX);
    idx_inc   = idx_q + 32'd1;
  end

  // Next-state logic for the frame parser and write sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    word_d  = word_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cksum_d = cksum_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        // Only a sync byte starts a frame; everything else is dropped.
        if (rx_fire && rx_data == SYNC_BYTE) begin
          state_d = ST_LEN;
          cnt_d   = '0;
          shift_d = '0;
          len_d   = '0;
          idx_d   = '0;
          cksum_d = '0;
        end
      end

      ST_LEN: begin
        if (rx_fire) begin
          cksum_d = cksum_q + rx_data;
          shift_d = assembled[31:8];
          cnt_d   = cnt_q + 2'd1;
          if (last_byte) begin
            len_d = assembled;
            if (assembled == 32'd0)     state_d = ST_CHK;
            else if (assembled > MAX_W) state_d = ST_ERR;
            else                        state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (rx_fire) begin
          cksum_d = cksum_q + rx_data;
          shift_d = assembled[31:8];
          cnt_d   = cnt_q + 2'd1;
          if (last_byte) begin
            word_d  = assembled;
            state_d = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        // Request stays on the bus, unchanged, until memory accepts it.
        if (mem_ready) begin
          idx_d   = idx_inc;
          state_d = (idx_inc == len_q) ? ST_CHK : ST_DATA;
        end
      end

      ST_CHK: begin
        if (rx_fire) state_d = (rx_data == cksum_q) ? ST_DONE : ST_ERR;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      cksum_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cksum_q <= cksum_d;
    end
  end

  // Outputs decode straight from the registered state so reset clears them
  // on the same edge that leaves WRITE.
  always_comb begin
    mem_instr   = 1'b0;
    mem_valid   = (state_q == ST_WRITE);
    mem_addr    = mem_valid ? (BASE_ADDR + (idx_q << 2)) : 32'd0;
    mem_wdata   = mem_valid ? word_q : 32'd0;
    mem_wstrb   = mem_valid ? 4'b1111 : 4'b0000;
    done        = (state_q == ST_DONE);
    error       = (state_q == ST_ERR);
    cpu_reset_n = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: frames are built from a list of words,
// the expected writes and final status come from a simple frame model, and a
// memory responder captures writes with a programmable acceptance latency.
module tb_prog_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int MAXW = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        cpu_reset_n, done, error;

  int tests = 0;
  int fails = 0;

  logic [31:0] words[$];   // payload of the next frame
  logic [31:0] cap_a[$];   // captured write addresses
  logic [31:0] cap_d[$];   // captured write data
  int          mem_lat = 1;
  int          vseen   = 0;

  prog_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .cpu_reset_n(cpu_reset_n), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder: accepts after mem_lat waiting cycles, checks the
  // request stays stable and the receiver is stalled meanwhile.
  initial begin
    int rcnt;
    logic [31:0] snap_a, snap_d;
    rcnt = 0; snap_a = '0; snap_d = '0;
    mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (reset) begin
        rcnt = 0;
      end else if (mem_valid) begin
        vseen++;
        if (rcnt == 0) begin
          snap_a = mem_addr;
          snap_d = mem_wdata;
        end else begin
          chk("addr_stable", mem_addr, snap_a);
          chk("wdata_stable", mem_wdata, snap_d);
        end
        chk("wstrb", {28'd0, mem_wstrb}, 32'hF);
        chk("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
        if (rcnt >= mem_lat) begin
          cap_a.push_back(mem_addr);
          cap_d.push_back(mem_wdata);
          mem_ready = 1'b1;
          rcnt = 0;
        end else begin
          rcnt++;
        end
      end else begin
        rcnt = 0;
        if (mem_wdata !== 32'd0) chk("wdata_idle", mem_wdata, 32'd0);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offer one byte and hold it until the loader takes it.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("byte_accept_timeout", 32'(n < 200), 32'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  // Send a full frame from 'words'; expected results derive from the frame.
  task automatic run_frame(input bit corrupt, input int lat);
    logic [31:0] n;
    logic [7:0]  b;
    int          s;
    n = 32'(words.size());
    s = 0;
    mem_lat = lat;
    cap_a.delete();
    cap_d.delete();
    vseen = 0;
    send_byte(8'hA5);
    chk("sync_clears_done", {31'd0, done}, 32'd0);
    chk("sync_clears_error", {31'd0, error}, 32'd0);
    chk("sync_cpu_reset", {31'd0, cpu_reset_n}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      b = 8'(n >> (8 * k));
      s += int'(b);
      send_byte(b);
    end
    foreach (words[w]) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'(words[w] >> (8 * k));
        s += int'(b);
        send_byte(b);
      end
    end
    b = 8'(s) + 8'(corrupt);
    send_byte(b);
    chk("num_writes", 32'(cap_a.size()), n);
    for (int w = 0; w < words.size() && w < cap_a.size(); w++) begin
      chk("write_addr", cap_a[w], BASE + 32'(4 * w));
      chk("write_data", cap_d[w], words[w]);
    end
    chk("done", {31'd0, done}, 32'(!corrupt));
    chk("error", {31'd0, error}, 32'(corrupt));
    chk("cpu_reset_n", {31'd0, cpu_reset_n}, 32'(!corrupt));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    chk({tag, "_mem_valid"}, {31'd0, mem_valid}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_wstrb"}, {28'd0, mem_wstrb}, 32'd0);
    chk({tag, "_cpu_reset_n"}, {31'd0, cpu_reset_n}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_mem_instr"}, {31'd0, mem_instr}, 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1 chk("rx_ready_after_reset", {31'd0, rx_ready}, 32'd1);

    // Stray bytes then a zero-length frame: no writes, load succeeds.
    send_byte(8'h00);
    send_byte(8'hFF);
    chk("stray_ignored_done", {31'd0, done}, 32'd0);
    words.delete();
    run_frame(1'b0, 1);
    chk("zero_len_no_valid", 32'(vseen), 32'd0);

    // Reference two-word frame, good and corrupted checksum.
    words = '{32'h1234_5678, 32'hDEAD_BEEF};
    run_frame(1'b0, 1);
    run_frame(1'b1, 1);

    // Memory stalls for 5 cycles while bytes are waiting.
    words = '{32'hCAFE_F00D, 32'h0BAD_A5A5, 32'hA5A5_A5A5};
    run_frame(1'b0, 5);

    // Randomised frames.
    for (int f = 0; f < 6; f++) begin
      words.delete();
      for (int w = 0, nw = $urandom_range(1, 8); w < nw; w++) words.push_back($urandom);
      run_frame($urandom_range(0, 3) == 0, $urandom_range(0, 6));
    end

    // Largest accepted count.
    words.delete();
    for (int w = 0; w < MAXW; w++) words.push_back($urandom);
    run_frame(1'b0, 0);

    // One word too many: error right after the count, nothing written.
    vseen = 0;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h00);
    chk("oversize_not_yet_err", {31'd0, error}, 32'd0);
    send_byte(8'h00);
    chk("oversize_error", {31'd0, error}, 32'd1);
    chk("oversize_cpu_reset", {31'd0, cpu_reset_n}, 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("oversize_no_valid", 32'(vseen), 32'd0);

    // Reset in the middle of a write, then reload one word.
    mem_lat = 1000;
    send_byte(8'hA5);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    repeat (2) @(posedge clk);
    #1 chk("midwrite_valid", {31'd0, mem_valid}, 32'd1);
    chk("midwrite_addr", mem_addr, BASE);
    chk("midwrite_data", mem_wdata, 32'h4433_2211);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 check_reset_outputs("midwrite_reset");
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1 chk("rx_ready_after_reset2", {31'd0, rx_ready}, 32'd1);
    words = '{32'h7654_3210};
    run_frame(1'b0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
